// File: rtl/canny_sobel_grad.sv
// canny_sobel_grad: streaming Sobel gradient magnitude and quantised direction over a 3x3 window
// ports: clk, reset (async, active low); in_valid/in_sof/in_pix raster pixel stream, no backpressure;
//        out_valid/out_mag/out_dir/out_eof registered result per interior pixel, 2 cycles after accept
module canny_sobel_grad #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    output logic [PIX_W+2:0] out_mag,
    output logic [1:0]       out_dir,
    output logic             out_eof
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int W  = PIX_W + 3;
    localparam int DW = W + 3;
    localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);

    logic [CW-1:0] col, ccol;
    logic [RW-1:0] row, crow;
    logic active, acc, last, v1, e1;
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] p [3][3];
    logic signed [W-1:0] gx, gy;
    logic [W-1:0] ax, ay;
    logic [1:0] dir;

    function automatic logic signed [W-1:0] sx(input logic [PIX_W-1:0] v);
        return signed'(W'(v));
    endfunction

    // in_sof overrides the running position so a new frame can start at any time
    always_comb begin
        acc  = in_valid & (in_sof | active);
        ccol = in_sof ? '0 : col;
        crow = in_sof ? '0 : row;
        last = (crow == RMAX) && (ccol == CMAX);
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            lb0[ccol] <= lb1[ccol];
            lb1[ccol] <= in_pix;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row       <= '0;
            col       <= '0;
            active    <= 1'b0;
            v1        <= 1'b0;
            e1        <= 1'b0;
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            out_mag   <= '0;
            out_dir   <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    p[r][c] <= '0;
        end else begin
            v1        <= acc && crow >= RW'(2) && ccol >= CW'(2);
            e1        <= acc && last;
            out_valid <= v1;
            out_eof   <= e1;
            out_mag   <= ax + ay;
            out_dir   <= dir;
            if (acc) begin
                active <= !last;
                col    <= (last || ccol == CMAX) ? '0 : ccol + CW'(1);
                row    <= last ? '0 : (ccol == CMAX) ? crow + RW'(1) : crow;
                for (int r = 0; r < 3; r++) begin
                    p[r][0] <= p[r][1];
                    p[r][1] <= p[r][2];
                end
                p[0][2] <= lb0[ccol];
                p[1][2] <= lb1[ccol];
                p[2][2] <= in_pix;
            end
        end
    end

    // widened products keep ay*5 / ax*5 from overflowing the magnitude width
    always_comb begin
        gx  = sx(p[0][2]) + (sx(p[1][2]) <<< 1) + sx(p[2][2])
            - sx(p[0][0]) - (sx(p[1][0]) <<< 1) - sx(p[2][0]);
        gy  = sx(p[2][0]) + (sx(p[2][1]) <<< 1) + sx(p[2][2])
            - sx(p[0][0]) - (sx(p[0][1]) <<< 1) - sx(p[0][2]);
        ax  = gx[W-1] ? W'(-gx) : W'(gx);
        ay  = gy[W-1] ? W'(-gy) : W'(gy);
        dir = (DW'(ay) * DW'(5) <= DW'(ax) * DW'(2)) ? 2'd0 :
              (DW'(ay) * DW'(2) >= DW'(ax) * DW'(5)) ? 2'd2 :
              (gx[W-1] == gy[W-1]) ? 2'd1 : 2'd3;
    end
endmodule

// File: tb/tb_canny_sobel_grad.sv
// tb_canny_sobel_grad: scoreboard bench for canny_sobel_grad on an 8x6 frame
module tb_canny_sobel_grad;
    localparam int W = 8;
    localparam int H = 6;
    localparam int P = 8;

    logic clk = 0, reset = 0, in_valid = 0, in_sof = 0;
    logic [P-1:0] in_pix = '0;
    logic out_valid, out_eof;
    logic [P+2:0] out_mag;
    logic [1:0] out_dir;

    canny_sobel_grad #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
        .out_valid(out_valid), .out_mag(out_mag), .out_dir(out_dir), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    typedef struct { int mag; int dir; int eof; int t; } exp_t;
    exp_t q[$];
    exp_t e;
    int cyc = 0, checks = 0, errors = 0, pulses = 0, eofs = 0;
    int img [H][W];
    int cur [H][W];
    int mr = 0, mc = 0;
    bit mfa = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model(int r, int c, output int mag, output int dir);
        int gx, gy, ax, ay;
        gx = (cur[r-2][c] + 2*cur[r-1][c] + cur[r][c]) - (cur[r-2][c-2] + 2*cur[r-1][c-2] + cur[r][c-2]);
        gy = (cur[r][c-2] + 2*cur[r][c-1] + cur[r][c]) - (cur[r-2][c-2] + 2*cur[r-2][c-1] + cur[r-2][c]);
        ax = gx < 0 ? -gx : gx;
        ay = gy < 0 ? -gy : gy;
        mag = ax + ay;
        if (ay*5 <= ax*2) dir = 0;
        else if (ay*2 >= ax*5) dir = 2;
        else if ((gx < 0) == (gy < 0)) dir = 1;
        else dir = 3;
    endfunction

    always @(negedge clk) begin
        if (reset && out_valid) begin
            pulses++;
            if (out_eof) eofs++;
            if (q.size() == 0) check("unexpected_out", 1, 0);
            else begin
                e = q.pop_front();
                check("mag", out_mag, e.mag);
                check("dir", out_dir, e.dir);
                check("eof", out_eof, e.eof);
                check("latency", cyc, e.t);
            end
        end else if (reset && out_eof) check("eof_without_valid", 1, 0);
    end

    task automatic drive(bit v, bit s, int px);
        int m, d;
        @(negedge clk);
        #1;
        in_valid = v;
        in_sof = s;
        in_pix = P'(px);
        if (v && s) begin mr = 0; mc = 0; mfa = 1; end
        if (v && mfa) begin
            cur[mr][mc] = px;
            if (mr >= 2 && mc >= 2) begin
                model(mr, mc, m, d);
                q.push_back('{m, d, int'(mr == H-1 && mc == W-1), cyc + 2});
            end
            if (mc == W-1) begin
                mc = 0;
                if (mr == H-1) begin mr = 0; mfa = 0; end else mr++;
            end else mc++;
        end
    endtask

    task automatic send(int gap, int sr = H-1, int sc = W-1);
        int n;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (r > sr || (r == sr && c > sc)) return;
                drive(1, r == 0 && c == 0, img[r][c]);
                n = gap < 0 ? int'($urandom_range(0, 3)) : gap;
                repeat (n) drive(0, 0, 0);
            end
    endtask

    task automatic flush();
        int n = 0;
        drive(0, 0, 0);
        while (q.size() > 0 && n < 60) begin drive(0, 0, 0); n++; end
        check("drain_timeout", q.size(), 0);
        repeat (3) drive(0, 0, 0);
    endtask

    task automatic fill(int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0: img[r][c] = 100;
                    1: img[r][c] = c < 4 ? 0 : 200;
                    2: img[r][c] = r < 3 ? 0 : 200;
                    3: img[r][c] = 20 * (r + c);
                    4: img[r][c] = 20 * (r + 7 - c);
                    5: img[r][c] = 255 * int'($urandom_range(0, 1));
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    task automatic frame(int pat, int gap);
        fill(pat);
        pulses = 0;
        eofs = 0;
        send(gap);
        flush();
        check("pulses", pulses, 24);
        check("eof_count", eofs, 1);
    endtask

    initial begin
        repeat (3) drive(0, 0, 0);
        check("rst_valid", out_valid, 0);
        check("rst_mag", out_mag, 0);
        check("rst_dir", out_dir, 0);
        check("rst_eof", out_eof, 0);
        reset = 1;
        repeat (3) drive(1, 0, 55);
        repeat (3) drive(0, 0, 0);
        frame(0, 0);
        frame(1, 0);
        frame(2, 0);
        frame(3, 0);
        frame(4, 0);
        frame(0, 2);
        repeat (2) drive(1, 0, 77);
        frame(5, -1);
        frame(6, 0);
        frame(6, -1);

        fill(6);
        send(0, 3, 5);
        @(negedge clk);
        #1;
        reset = 0;
        in_valid = 0;
        in_sof = 0;
        q.delete();
        mfa = 0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_mag", out_mag, 0);
        check("midrst_eof", out_eof, 0);
        @(negedge clk);
        #1;
        reset = 1;
        repeat (4) drive(1, 0, 33);
        frame(6, 0);

        pulses = 0;
        eofs = 0;
        fill(6);
        send(0, 3, 5);
        fill(6);
        send(0);
        flush();
        check("sof_pulses", pulses, 34);
        check("sof_eof_count", eofs, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
